// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between a MEM-stage requester and data_ram_ctrl.
interface data_ram_ctrl_if #(
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic              we;
   logic [31:0]       addr;
   logic [1:0]        size;
   logic              sign_ext;
   logic [DATA_W-1:0] data_i;
   logic              ready;
   logic              ack;
   logic [DATA_W-1:0] data_o;
   logic              err;

   modport master (
      output req, we, addr, size, sign_ext, data_i,
      input  ready, ack, data_o, err
   );

   modport slave (
      input  req, we, addr, size, sign_ext, data_i,
      output ready, ack, data_o, err
   );
endinterface

// File: rtl/data_ram_ctrl.sv
// Handshaked big-endian byte-lane data RAM with programmable wait states.
// DATA_RAM_ALIGN_CHECK_EN: flag misaligned accesses with err instead of aligning them down.
module data_ram_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH_LOG2  = 17,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic            clk,
   input logic            rst,
   data_ram_ctrl_if.slave bus
);

   localparam int unsigned NUM_BYTES = DATA_W / 8;
   localparam int unsigned OFF_W     = $clog2(NUM_BYTES);
   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  we_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [OFF_W-1:0]      off_q;
   logic [1:0]            size_q;
   logic                  sext_q;
   logic [DATA_W-1:0]     wdata_q;

   logic                  accept, commit;
   int unsigned           eff_log2, nbytes;
   logic [OFF_W-1:0]      off_eff;
   logic                  bad;
   logic                  sign;
   logic [NUM_BYTES-1:0]  lane_we;
   logic [7:0]            lane_wdata [NUM_BYTES];
   logic [DATA_W-1:0]     load_val;

   logic [7:0]            mem [NUM_BYTES][DEPTH];

   // Effective size saturates at the bus width, so dword on a 32-bit bus is a word.
   always_comb begin
      eff_log2 = (32'(size_q) > OFF_W) ? OFF_W : 32'(size_q);
      nbytes   = 32'd1 << eff_log2;
`ifdef DATA_RAM_ALIGN_CHECK_EN
      off_eff  = off_q;
      bad      = (32'(off_q) & (nbytes - 32'd1)) != 32'd0;
`else
      off_eff  = off_q & ~OFF_W'(nbytes - 32'd1);
      bad      = 1'b0;
`endif
   end

   always_comb begin
      sign     = sext_q & mem[off_eff][idx_q][7];
      load_val = '0;
      for (int unsigned j = 0; j < NUM_BYTES; j++) begin
         if (j < nbytes) begin
            load_val[j*8 +: 8] = mem[OFF_W'(32'(off_eff) + nbytes - 32'd1 - j)][idx_q];
         end else begin
            load_val[j*8 +: 8] = {8{sign}};
         end
      end
   end

   // Right-justified store data: the last byte of the access lands in the highest lane.
   always_comb begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
         lane_we[b]    = 1'b0;
         lane_wdata[b] = 8'h00;
         if (b >= 32'(off_eff) && b < 32'(off_eff) + nbytes) begin
            lane_we[b]    = commit & we_q & ~bad & ~rst;
            lane_wdata[b] = wdata_q[(32'(off_eff) + nbytes - 32'd1 - b)*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      accept  = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               accept  = 1'b1;
               state_d = StWait;
               cnt_d   = 4'(WAIT_STATES);
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               commit  = 1'b1;
               state_d = StDone;
               rdata_d = (we_q || bad) ? '0 : load_val;
               err_d   = bad;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         off_q   <= '0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= bus.we;
            idx_q   <= bus.addr[DEPTH_LOG2+OFF_W-1:OFF_W];
            off_q   <= bus.addr[OFF_W-1:0];
            size_q  <= bus.size;
            sext_q  <= bus.sign_ext;
            wdata_q <= bus.data_i;
         end
      end
   end

   for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
      always_ff @(posedge clk) begin
         if (lane_we[g]) begin
            mem[g][idx_q] <= lane_wdata[g];
         end
      end
   end

   assign bus.ready  = (state_q == StIdle);
   assign bus.ack    = (state_q == StDone);
   assign bus.data_o = rdata_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: four instances (32-bit WS=0/2/3, 64-bit WS=1) on one clock.
module tb_data_ram_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  rst_v;
   logic        req_c = 1'b0, we_c = 1'b0, sext_c = 1'b0;
   logic [31:0] addr_c = '0;
   logic [1:0]  size_c = '0;
   logic [63:0] wdata_c = '0;
   int          sel = 0;
   int          n_vec = 0, n_bad = 0;

   logic        ready_m, ack_m, err_m;
   logic [63:0] rdata_m;

   data_ram_ctrl_if #(.DATA_W(32)) bus0 ();
   data_ram_ctrl_if #(.DATA_W(32)) bus2 ();
   data_ram_ctrl_if #(.DATA_W(32)) bus3 ();
   data_ram_ctrl_if #(.DATA_W(64)) bus64 ();

   assign bus0.req  = req_c && sel == 0;
   assign bus2.req  = req_c && sel == 1;
   assign bus3.req  = req_c && sel == 2;
   assign bus64.req = req_c && sel == 3;
   assign bus0.we   = we_c;   assign bus2.we   = we_c;   assign bus3.we   = we_c;
   assign bus64.we  = we_c;
   assign bus0.addr = addr_c; assign bus2.addr = addr_c; assign bus3.addr = addr_c;
   assign bus64.addr = addr_c;
   assign bus0.size = size_c; assign bus2.size = size_c; assign bus3.size = size_c;
   assign bus64.size = size_c;
   assign bus0.sign_ext = sext_c; assign bus2.sign_ext = sext_c;
   assign bus3.sign_ext = sext_c; assign bus64.sign_ext = sext_c;
   assign bus0.data_i = wdata_c[31:0]; assign bus2.data_i = wdata_c[31:0];
   assign bus3.data_i = wdata_c[31:0]; assign bus64.data_i = wdata_c;

   always_comb begin
      ready_m = bus0.ready;  ack_m = bus0.ack;  err_m = bus0.err;  rdata_m = {32'h0, bus0.data_o};
      case (sel)
         1: begin ready_m = bus2.ready; ack_m = bus2.ack; err_m = bus2.err;
                  rdata_m = {32'h0, bus2.data_o}; end
         2: begin ready_m = bus3.ready; ack_m = bus3.ack; err_m = bus3.err;
                  rdata_m = {32'h0, bus3.data_o}; end
         3: begin ready_m = bus64.ready; ack_m = bus64.ack; err_m = bus64.err;
                  rdata_m = bus64.data_o; end
         default: ;
      endcase
   end

   data_ram_ctrl #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst_v[0]), .bus(bus0.slave));
   data_ram_ctrl #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst(rst_v[1]), .bus(bus2.slave));
   data_ram_ctrl #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst_v[2]), .bus(bus3.slave));
   data_ram_ctrl #(.DATA_W(64), .DEPTH_LOG2(8), .WAIT_STATES(1)) u_d64 (
      .clk(clk), .rst(rst_v[3]), .bus(bus64.slave));

   // One request: waits for ready, holds req through accept, returns ack data and latency.
   task automatic access(input int s, input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic sx, input logic [63:0] wd,
                         output logic [63:0] rd, output logic e, output int lat);
      @(negedge clk);
      sel = s; we_c = we; addr_c = a; size_c = sz; sext_c = sx; wdata_c = wd; req_c = 1'b1;
      for (int i = 0; i < 50 && !ready_m; i++) @(negedge clk);
      @(negedge clk);
      req_c = 1'b0;
      lat = 1;
      while (!ack_m && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      rd = rdata_m;
      e  = err_m;
   endtask

   task automatic test_reset();
      rst_v = 4'hF;
      repeat (3) @(negedge clk);
      rst_v = 4'h0;
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         n_vec++;
         if ({ready_m, ack_m, err_m, rdata_m} !== {3'b100, 64'h0}) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: got rdy=%b ack=%b err=%b d=%h want 1 0 0 0",
                     s, ready_m, ack_m, err_m, rdata_m);
         end
      end
   endtask

   task automatic test_word_store();
      logic [63:0] rd; logic e; int lat;
      access(0, 1'b1, 32'h10, 2'b10, 1'b0, 64'h11223344, rd, e, lat);
      n_vec++;
      if ({lat, rd, e} !== {32'd2, 64'h0, 1'b0}) begin
         n_bad++; $display("FAIL st_word: got lat=%0d d=%h err=%b want 2 0 0", lat, rd, e);
      end
      access(0, 1'b0, 32'h11, 2'b00, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if ({lat, rd} !== {32'd2, 64'h22}) begin
         n_bad++; $display("FAIL ld_byte_zx: got lat=%0d d=%h want 2 22", lat, rd);
      end
      access(0, 1'b0, 32'h12, 2'b01, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h3344) begin n_bad++; $display("FAIL ld_half: got %h want 3344", rd); end
      access(0, 1'b0, 32'h10, 2'b11, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h11223344) begin
         n_bad++; $display("FAIL ld_dword_as_word: got %h want 11223344", rd);
      end
      access(0, 1'b0, 32'h410, 2'b10, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h11223344) begin
         n_bad++; $display("FAIL ld_alias: got %h want 11223344", rd);
      end
   endtask

   task automatic test_byte_sign();
      logic [63:0] rd; logic e; int lat;
      access(0, 1'b1, 32'h20, 2'b10, 1'b0, 64'h01020304, rd, e, lat);
      access(0, 1'b1, 32'h20, 2'b00, 1'b0, 64'hA580, rd, e, lat);
      n_vec++;
      if ({rd, e} !== {64'h0, 1'b0}) begin
         n_bad++; $display("FAIL st_byte: got d=%h err=%b want 0 0", rd, e);
      end
      access(0, 1'b0, 32'h20, 2'b00, 1'b1, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'hFFFFFF80) begin
         n_bad++; $display("FAIL ld_byte_sx: got %h want ffffff80", rd);
      end
      access(0, 1'b0, 32'h20, 2'b00, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h80) begin n_bad++; $display("FAIL ld_byte_zx80: got %h want 80", rd); end
      access(0, 1'b0, 32'h20, 2'b10, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h80020304) begin
         n_bad++; $display("FAIL byte_neighbours: got %h want 80020304", rd);
      end
   endtask

   task automatic test_align();
      logic [63:0] rd; logic e; int lat;
      logic [63:0] exp_word;
      logic        exp_err;
`ifdef DATA_RAM_ALIGN_CHECK_EN
      exp_err = 1'b1; exp_word = 64'h11223344;
`else
      exp_err = 1'b0; exp_word = 64'h1122BEEF;
`endif
      access(0, 1'b1, 32'h13, 2'b01, 1'b0, 64'hBEEF, rd, e, lat);
      n_vec++;
      if ({lat, rd, e} !== {32'd2, 64'h0, exp_err}) begin
         n_bad++;
         $display("FAIL misaligned_st: got lat=%0d d=%h err=%b want 2 0 %b", lat, rd, e, exp_err);
      end
      access(0, 1'b0, 32'h10, 2'b10, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if ({rd, e} !== {exp_word, 1'b0}) begin
         n_bad++; $display("FAIL misaligned_after: got d=%h err=%b want %h 0", rd, e, exp_word);
      end
   endtask

   task automatic test_back_to_back();
      int   acks;
      logic exp_rdy, exp_ack;
      @(negedge clk);
      sel = 1; we_c = 1'b1; addr_c = 32'h30; size_c = 2'b10; sext_c = 1'b0;
      wdata_c = 64'hCAFEF00D; req_c = 1'b1;
      acks = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         exp_rdy = (c == 5) || (c >= 10);
         exp_ack = (c == 4) || (c == 9);
         n_vec++;
         if ({ready_m, ack_m} !== {exp_rdy, exp_ack}) begin
            n_bad++;
            $display("FAIL b2b_cycle%0d: got rdy=%b ack=%b want %b %b",
                     c, ready_m, ack_m, exp_rdy, exp_ack);
         end
         if (ack_m) acks++;
         if (c == 4) we_c = 1'b0;
         if (c == 6) req_c = 1'b0;
         if (c == 9) begin
            n_vec++;
            if (rdata_m !== 64'hCAFEF00D) begin
               n_bad++; $display("FAIL b2b_load: got %h want cafef00d", rdata_m);
            end
         end
      end
      n_vec++;
      if (acks !== 2) begin n_bad++; $display("FAIL b2b_acks: got %0d want 2", acks); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] rd; logic e; int lat; int acks;
      access(2, 1'b1, 32'h40, 2'b10, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (lat !== 5) begin n_bad++; $display("FAIL ws3_latency: got %0d want 5", lat); end
      @(negedge clk);
      sel = 2; we_c = 1'b1; addr_c = 32'h40; size_c = 2'b10; wdata_c = 64'hDEADBEEF;
      req_c = 1'b1;
      @(negedge clk);
      req_c = 1'b0;
      @(negedge clk);
      rst_v[2] = 1'b1;
      @(negedge clk);
      rst_v[2] = 1'b0;
      n_vec++;
      if ({ready_m, ack_m} !== 2'b10) begin
         n_bad++; $display("FAIL rst_mid_idle: got rdy=%b ack=%b want 1 0", ready_m, ack_m);
      end
      acks = 0;
      repeat (10) begin
         @(negedge clk);
         if (ack_m) acks++;
      end
      n_vec++;
      if (acks !== 0) begin n_bad++; $display("FAIL rst_mid_noack: got %0d want 0", acks); end
      access(2, 1'b0, 32'h40, 2'b10, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h0) begin n_bad++; $display("FAIL rst_mid_nowrite: got %h want 0", rd); end
   endtask

   task automatic test_dword();
      logic [63:0] rd; logic e; int lat;
      access(3, 1'b1, 32'h8, 2'b11, 1'b0, 64'h0102030405060708, rd, e, lat);
      n_vec++;
      if ({lat, rd} !== {32'd3, 64'h0}) begin
         n_bad++; $display("FAIL d64_store: got lat=%0d d=%h want 3 0", lat, rd);
      end
      access(3, 1'b0, 32'hC, 2'b10, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h0000000005060708) begin
         n_bad++; $display("FAIL d64_ld_word: got %h want 0000000005060708", rd);
      end
      access(3, 1'b0, 32'h8, 2'b11, 1'b0, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'h0102030405060708) begin
         n_bad++; $display("FAIL d64_ld_dword: got %h want 0102030405060708", rd);
      end
      access(3, 1'b1, 32'h10, 2'b10, 1'b0, 64'h89ABCDEF, rd, e, lat);
      access(3, 1'b0, 32'h10, 2'b10, 1'b1, 64'h0, rd, e, lat);
      n_vec++;
      if (rd !== 64'hFFFFFFFF89ABCDEF) begin
         n_bad++; $display("FAIL d64_ld_word_sx: got %h want ffffffff89abcdef", rd);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_store();
      test_byte_sign();
      test_align();
      test_back_to_back();
      test_reset_mid();
      test_dword();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Parametrised, handshaked data RAM for the MEM stage.
- Supports configurable data width, depth and wait states.
- Handles byte, halfword and word (plus doubleword at 64-bit) loads and stores, with big-endian lane steering and sign/zero extension on loads.
- Fronts the banked byte-lane memory behind a req/ready/ack protocol so that slower memory timing can be modelled.

Parameters:
- DATA_W, 32: data bus width; 32 or 64; NUM_BYTES = DATA_W/8 byte lanes.
- DEPTH_LOG2, 17: log2 of the number of words per lane bank.
- WAIT_STATES, 0: extra cycles between request accept and memory commit; range 0..15.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request valid.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- size  input  2  access size; 00 = byte, 01 = half, 10 = word, 11 = dword.
- sign_ext  input  1  loads only; 1 = sign-extend, 0 = zero-extend.
- data_i  input  DATA_W  store data, right-justified.
- ready  output  1  controller can accept a request this cycle.
- ack  output  1  one-cycle response strobe.
- data_o  output  DATA_W  load result; valid only while ack = 1.
- err  output  1  misaligned access; valid with ack.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state = IDLE, ready = 1, ack = 0, data_o = 0, err = 0, wait counter = 0. Memory contents are not reset.
- Memory organisation: NUM_BYTES banks, each 2^DEPTH_LOG2 x 8.
  - Word index = addr[DEPTH_LOG2+log2(NUM_BYTES)-1 : log2(NUM_BYTES)].
  - Higher address bits are ignored (the memory aliases).
- Lane ordering is big-endian: byte offset 0 maps to data[DATA_W-1 -: 8].
- Effective size = min(2^size, NUM_BYTES) bytes. size = 11 at DATA_W = 32 is treated as a word access.
- State machine: IDLE -> WAIT -> DONE -> IDLE.
  - ready = 1 only in IDLE.
  - Accept occurs on the edge where req = 1 and ready = 1. At accept, we, addr, size, sign_ext and data_i are latched and the counter is loaded with WAIT_STATES.
  - WAIT: the counter decrements each cycle. When it is 0, the next edge commits and the state moves to DONE. With WAIT_STATES = 0, WAIT lasts exactly one cycle.
  - Commit edge:
    - Store: writes only the lanes covered by the access.
    - Load: reads the lanes, right-justifies the bytes and extends them to DATA_W per sign_ext. The result is registered into data_o.
  - DONE: ack = 1 for exactly one cycle; the next state is IDLE.
- Latency: ack is high in cycle accept+WAIT_STATES+2, counting the accept-edge cycle as accept+0. Throughput is one request per WAIT_STATES+3 cycles.
- Store ack: data_o = 0.
- Requests while ready = 0 are ignored and not queued; the requester holds req until it is accepted.
- Misalignment (addr offset not a multiple of the effective size) is handled as described under Optional Feature.
- Reset mid-operation: rst has priority over everything. A store whose commit edge coincides with, or follows, rst = 1 is not written. No ack is produced for an abandoned request.
- Combinational paths: ready depends only on state. There is no combinational path from req to ack or data_o.

Optional Feature:
- Macro: DATA_RAM_ALIGN_CHECK_EN.
- Defined:
  - A misaligned request is still accepted and takes the normal latency.
  - No memory write occurs.
  - The ack cycle carries err = 1 and data_o = 0.
  - Aligned accesses give err = 0.
- Undefined:
  - The address offset bits below the effective size are forced to 0, so the access is aligned down.
  - err is tied to 0.

Test Plan:
- WAIT_STATES = 0, DATA_W = 32. Store word 0x11223344 @0x10. Then:
  - Load byte @0x11, zero-extend -> ack at accept+2, data_o = 0x00000022.
  - Load half @0x12 -> 0x00003344.
- Store byte 0x80 @0x20 (data_i = 0x000000A5_80 low byte 0x80). Then:
  - Load byte @0x20 with sign_ext = 1 -> 0xFFFFFF80.
  - Load byte @0x20 with sign_ext = 0 -> 0x00000080.
  - Other bytes of word 0x20 are unchanged.
- WAIT_STATES = 2, back-to-back req held high:
  - ready is low from accept+1 through the ack cycle.
  - ack occurs at accept+4.
  - The second request is accepted on the first cycle in which ready = 1.
  - No request is lost or duplicated.
- DATA_RAM_ALIGN_CHECK_EN defined. Store half 0xBEEF @0x13 -> ack with err = 1. A subsequent load word @0x10 returns the prior contents unchanged.
  - Macro undefined: the same store writes 0xBEEF at byte offsets 2..3 of word 0x10, and err = 0.
- Store word 0xDEADBEEF @0x40 with WAIT_STATES = 3, and assert rst for one cycle at accept+2:
  - No ack.
  - State returns to IDLE with ready = 1.
  - A later load word @0x40 does not return 0xDEADBEEF when memory is pre-initialised to 0.
- DATA_W = 64:
  - Store dword 0x0102030405060708 @0x8, then load word @0xC -> 0x0000000005060708 (zero-extended).
  - Load size = 11 @0x8 -> 0x0102030405060708.
